id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pipe_pkg.sv | 19 +
 rtl/id_ex_stage_fwd_select.sv | 30 +++
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared control-bus layout and forwarding-select encodings for the MIPS pipeline.
package mips_pipe_pkg;

   localparam int unsigned CTRL_W        = 9;
   localparam int unsigned CTRL_REGDST   = 0;
   localparam int unsigned CTRL_ALUSRC   = 1;
   localparam int unsigned CTRL_MEMTOREG = 2;
   localparam int unsigned CTRL_REGWRITE = 3;
   localparam int unsigned CTRL_MEMREAD  = 4;
   localparam int unsigned CTRL_MEMWRITE = 5;
   localparam int unsigned CTRL_BRANCH   = 6;
   // ALUOp occupies [CTRL_ALUOP+1:CTRL_ALUOP]
   localparam int unsigned CTRL_ALUOP    = 7;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Forwarding select for one ALU operand; the newer EX/MEM result beats MEM/WB.
module fwd_select
   import mips_pipe_pkg::*;
(
   input  logic [4:0] src_reg,
   input  logic [4:0] ex_dest,
   input  logic       ex_valid,
   input  logic       ex_regwrite,
   input  logic [4:0] mem_dest,
   input  logic       mem_regwrite,
   output logic [1:0] sel
);

   logic ex_hit;
   logic mem_hit;

   // $0 is hardwired, so a write to it is never a forwarding source
   assign ex_hit  = ex_valid && ex_regwrite && (ex_dest != 5'd0) && (ex_dest == src_reg);
   assign mem_hit = mem_regwrite && (mem_dest != 5'd0) && (mem_dest == src_reg);

   always_comb begin
      sel = FWD_REG;
      if (ex_hit) begin
         sel = FWD_EXMEM;
      end else if (mem_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles and
// registered forwarding selects for the EX-stage operand muxes.
module id_ex_stage
   import mips_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [31:0]       id_pc4,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              flush,
   input  logic              mem_regwrite,
   input  logic [4:0]        mem_wr_reg,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_pc4,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic              stall
);

   logic [4:0] ex_dest;
   logic [1:0] fwd_a_next;
   logic [1:0] fwd_b_next;
   logic       bubble;

   assign ex_dest = ex_ctrl[CTRL_REGDST] ? ex_rd : ex_rt;

   // Load in EX whose result the ID instruction needs; flush overrides it
   assign stall = id_valid && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt)) && !flush;

   assign bubble = flush || stall;

   fwd_select u_fwd_a (
      .src_reg      (id_rs),
      .ex_dest      (ex_dest),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_ctrl[CTRL_REGWRITE]),
      .mem_dest     (mem_wr_reg),
      .mem_regwrite (mem_regwrite),
      .sel          (fwd_a_next)
   );

   fwd_select u_fwd_b (
      .src_reg      (id_rt),
      .ex_dest      (ex_dest),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_ctrl[CTRL_REGWRITE]),
      .mem_dest     (mem_wr_reg),
      .mem_regwrite (mem_regwrite),
      .sel          (fwd_b_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_pc4     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_fwd_a   <= FWD_REG;
         ex_fwd_b   <= FWD_REG;
      end else if (bubble) begin
         // Bubble only kills validity/control; data fields keep their contents
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_fwd_a <= FWD_REG;
         ex_fwd_b <= FWD_REG;
      end else begin
         ex_valid   <= id_valid;
         ex_ctrl    <= id_valid ? id_ctrl : '0;
         ex_pc4     <= id_pc4;
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         ex_fwd_a   <= fwd_a_next;
         ex_fwd_b   <= fwd_b_next;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, forwarding priority, load-use,
// flush-vs-stall, reset and $0 cases with hand-computed expectations.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [8:0]  id_ctrl;
   logic        flush;
   logic        mem_regwrite;
   logic [4:0]  mem_wr_reg;
   logic        ex_valid;
   logic [8:0]  ex_ctrl;
   logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic        stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_pc4       (id_pc4),
      .id_rs_data   (id_rs_data),
      .id_rt_data   (id_rt_data),
      .id_imm       (id_imm),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_ctrl      (id_ctrl),
      .flush        (flush),
      .mem_regwrite (mem_regwrite),
      .mem_wr_reg   (mem_wr_reg),
      .ex_valid     (ex_valid),
      .ex_ctrl      (ex_ctrl),
      .ex_pc4       (ex_pc4),
      .ex_rs_data   (ex_rs_data),
      .ex_rt_data   (ex_rt_data),
      .ex_imm       (ex_imm),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_rd        (ex_rd),
      .ex_fwd_a     (ex_fwd_a),
      .ex_fwd_b     (ex_fwd_b),
      .stall        (stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [8:0] ctrl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
      id_valid = v;
      id_ctrl  = ctrl;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 1'b0; id_ctrl = '0; id_rs = '0; id_rt = '0; id_rd = '0;
      id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      flush = 1'b0; mem_regwrite = 1'b0; mem_wr_reg = '0;
      #2;
      check("reset_valid", ex_valid, 0);
      check("reset_stall", stall, 0);

      // Plain pass-through
      tick();
      reset = 1'b0;
      drive(1, 9'h008, 5'd3, 5'd4, 5'd0);
      id_rs_data = 32'h11; id_rt_data = 32'h22; id_pc4 = 32'h104; id_imm = 32'hFFFF_FFF0;
      tick();
      check("pass_valid", ex_valid, 1);
      check("pass_ctrl", ex_ctrl, 9'h008);
      check("pass_rs_data", ex_rs_data, 32'h11);
      check("pass_rt_data", ex_rt_data, 32'h22);
      check("pass_pc4", ex_pc4, 32'h104);
      check("pass_imm", ex_imm, 32'hFFFF_FFF0);
      check("pass_rs", ex_rs, 3);
      check("pass_fwd_a", ex_fwd_a, 0);
      check("pass_fwd_b", ex_fwd_b, 0);

      // Forward priority: add $5 into EX, MEM/WB also writes $5
      drive(1, 9'h009, 5'd1, 5'd2, 5'd5);
      tick();
      check("add_ctrl", ex_ctrl, 9'h009);
      check("add_rd", ex_rd, 5);
      drive(1, 9'h008, 5'd5, 5'd5, 5'd6);
      mem_regwrite = 1'b1; mem_wr_reg = 5'd5;
      #1 check("prio_stall", stall, 0);
      tick();
      check("prio_fwd_a", ex_fwd_a, 2'b10);
      check("prio_fwd_b", ex_fwd_b, 2'b10);
      // Insert an invalid slot so EX holds nothing
      drive(0, 9'h009, 5'd0, 5'd0, 5'd0);
      mem_regwrite = 1'b0;
      tick();
      check("inv_valid", ex_valid, 0);
      check("inv_ctrl", ex_ctrl, 0);
      drive(1, 9'h008, 5'd5, 5'd5, 5'd6);
      mem_regwrite = 1'b1; mem_wr_reg = 5'd5;
      tick();
      check("memwb_fwd_a", ex_fwd_a, 2'b01);
      check("memwb_fwd_b", ex_fwd_b, 2'b01);

      // Load-use: lw $8 then consumer of $8
      mem_regwrite = 1'b0; mem_wr_reg = 5'd0;
      drive(1, 9'h01E, 5'd0, 5'd8, 5'd0);
      tick();
      drive(1, 9'h008, 5'd1, 5'd8, 5'd9);
      id_rt_data = 32'h77;
      #1 check("lu_stall", stall, 1);
      tick();
      check("lu_bub_valid", ex_valid, 0);
      check("lu_bub_ctrl", ex_ctrl, 0);
      check("lu_bub_rt_hold", ex_rt, 8);
      check("lu_bub_data_hold", ex_rt_data, 32'h22);
      check("lu_bub_fwd_b", ex_fwd_b, 0);
      check("lu_stall_drop", stall, 0);
      mem_regwrite = 1'b1; mem_wr_reg = 5'd8;
      tick();
      check("lu_valid", ex_valid, 1);
      check("lu_fwd_a", ex_fwd_a, 0);
      check("lu_fwd_b", ex_fwd_b, 2'b01);
      check("lu_rt_data", ex_rt_data, 32'h77);

      // Flush beats stall
      mem_regwrite = 1'b0;
      drive(1, 9'h01E, 5'd0, 5'd8, 5'd0);
      tick();
      drive(1, 9'h008, 5'd8, 5'd2, 5'd9);
      flush = 1'b1;
      #1 check("flush_stall", stall, 0);
      tick();
      check("flush_valid", ex_valid, 0);
      check("flush_ctrl", ex_ctrl, 0);
      flush = 1'b0;

      // Reset mid-stall, without a clock edge
      drive(1, 9'h01E, 5'd0, 5'd8, 5'd0);
      tick();
      drive(1, 9'h008, 5'd8, 5'd8, 5'd9);
      #1 check("rst_pre_stall", stall, 1);
      #1 reset = 1'b1;
      #1;
      check("rst_stall", stall, 0);
      check("rst_valid", ex_valid, 0);
      check("rst_ctrl", ex_ctrl, 0);
      check("rst_rs_data", ex_rs_data, 0);
      check("rst_pc4", ex_pc4, 0);
      check("rst_rt", ex_rt, 0);
      tick();
      reset = 1'b0;

      // $0: lw to $0 must not stall, write to $0 must not forward
      drive(1, 9'h01E, 5'd0, 5'd0, 5'd0);
      tick();
      check("z_first_valid", ex_valid, 1);
      drive(1, 9'h008, 5'd0, 5'd0, 5'd3);
      mem_regwrite = 1'b1; mem_wr_reg = 5'd0;
      #1 check("z_stall", stall, 0);
      tick();
      check("z_fwd_a", ex_fwd_a, 0);
      check("z_fwd_b", ex_fwd_b, 0);
      check("z_valid", ex_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
